and_reg_rr_arbiter: RTL and testbench

//  Shares one registered AND-evaluation stage (result <= a & b, sync reset) between
//  NUM_REQ requesters. Round-robin grant, one operand pair accepted per cycle max;

---
 rtl/and_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 35 +++
 rtl/and_reg_rr_arbiter.sv | 87 ++++++++
 tb/tb_and_reg_rr_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/and_arb_pkg.sv
// rtl/and_arb_pkg.sv - shared types and default sizes for the AND-stage arbiter
package and_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  // Occupancy of the single-entry result register
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at a rotating pointer
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  logic [NUM_REQ-1:0]   hi_mask;
  logic [2*NUM_REQ-1:0] dbl_req;
  int                   sel;

  // Requests at or above the pointer sit in the low half, all requests in the
  // high half; the lowest set bit of the double vector is the round-robin winner.
  always_comb begin
    hi_mask   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i >= int'(rr_ptr));
    end
    dbl_req   = {req, req & hi_mask};
    sel       = 0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (dbl_req[i]) sel = i;
    end
    any_grant = |req;
    grant_idx = (sel >= NUM_REQ) ? ID_W'(sel - NUM_REQ) : ID_W'(sel);
    grant     = '0;
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/and_reg_rr_arbiter.sv
// rtl/and_reg_rr_arbiter.sv - round-robin shared registered AND stage with valid/ready result
module and_reg_rr_arbiter
  import and_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  out_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_idx;
  logic                any_req;
  logic                can_accept;
  logic                grant;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any_grant (any_req)
  );

  // Accept when the result register is free or being drained this cycle; never during reset
  always_comb begin
    can_accept = (state == EMPTY) | res_ready;
    grant      = any_req & can_accept & ~reset;
    req_ready  = grant ? pick_onehot : '0;
    a_sel      = req_a[pick_idx*DATA_W +: DATA_W];
    b_sel      = req_b[pick_idx*DATA_W +: DATA_W];
    next_ptr   = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + ID_W'(1);
    busy       = res_valid | (|req_valid);
  end

  // Output-register FSM, rotation pointer and AND stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant) begin
            state     <= FULL;
            res_valid <= 1'b1;
          end
        end
        FULL: begin
          if (res_ready && !grant) begin
            state     <= EMPTY;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          res_valid <= 1'b0;
        end
      endcase
      if (grant) begin
        res_data <= a_sel & b_sel;
        res_id   <= pick_idx;
        rr_ptr   <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_and_reg_rr_arbiter.sv
// tb/tb_and_reg_rr_arbiter.sv - directed table-driven bench for and_reg_rr_arbiter
module tb_and_reg_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  and_reg_rr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       rr;
    logic [3:0] exp_rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_id;
    logic       chk_data;
  } vec_t;

  vec_t vecs[$];

  // Results per requester: AA&0F=0A, 55&FF=55, F0&3C=30, C3&81=81
  logic [7:0] res_of [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] rv, input logic rr,
                              input logic [3:0] rdy, input logic v, input logic [7:0] d,
                              input logic [1:0] id, input logic cd);
    vec_t t;
    t.rst = rst; t.rv = rv; t.rr = rr; t.exp_rdy = rdy;
    t.exp_valid = v; t.exp_data = d; t.exp_id = id; t.chk_data = cd;
    vecs.push_back(t);
  endfunction

  logic prev_valid;

  initial begin
    res_of[0] = 8'h0A; res_of[1] = 8'h55; res_of[2] = 8'h30; res_of[3] = 8'h81;
    req_a = {8'hC3, 8'hF0, 8'h55, 8'hAA};
    req_b = {8'h81, 8'h3C, 8'hFF, 8'h0F};

    // reset two cycles with all requests pending
    add(1, 4'hF, 1, 4'b0000, 0, 8'h00, 2'd0, 1);
    add(1, 4'hF, 1, 4'b0000, 0, 8'h00, 2'd0, 1);
    // rotation 0,1,2,3,0,1
    add(0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0, 1);
    add(0, 4'hF, 1, 4'b0010, 1, 8'h55, 2'd1, 1);
    add(0, 4'hF, 1, 4'b0100, 1, 8'h30, 2'd2, 1);
    add(0, 4'hF, 1, 4'b1000, 1, 8'h81, 2'd3, 1);
    add(0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0, 1);
    add(0, 4'hF, 1, 4'b0010, 1, 8'h55, 2'd1, 1);
    add(0, 4'h0, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    // single request from req 2
    add(0, 4'b0100, 1, 4'b0100, 1, 8'h30, 2'd2, 1);
    add(0, 4'h0, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    // pointer at 3, only req 1 pending: skip-and-wrap, pointer moves to 2
    add(0, 4'b0010, 1, 4'b0010, 1, 8'h55, 2'd1, 1);
    add(0, 4'h0, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    // grant of req 3 wraps pointer to 0, so req 0 wins over req 3
    add(0, 4'b1000, 1, 4'b1000, 1, 8'h81, 2'd3, 1);
    add(0, 4'b1001, 1, 4'b0001, 1, 8'h0A, 2'd0, 1);
    // backpressure: five stalled cycles, result held
    for (int k = 0; k < 5; k++) add(0, 4'hF, 0, 4'b0000, 1, 8'h0A, 2'd0, 1);
    add(0, 4'hF, 1, 4'b0010, 1, 8'h55, 2'd1, 1);
    add(0, 4'hF, 1, 4'b0100, 1, 8'h30, 2'd2, 1);
    add(0, 4'h0, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    // empty register accepts even without res_ready (pointer 3 -> pick 0 -> pointer 1)
    add(0, 4'b0001, 0, 4'b0001, 1, 8'h0A, 2'd0, 1);
    // reset while FULL and stalled: result dropped, pointer back to 0
    add(1, 4'hF, 0, 4'b0000, 0, 8'h00, 2'd0, 1);
    add(0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0, 1);
    add(0, 4'h0, 1, 4'b0000, 0, 8'h00, 2'd0, 0);

    reset = 1'b1; req_valid = '0; res_ready = 1'b0;
    prev_valid = 1'b0;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; req_valid = vecs[i].rv; res_ready = vecs[i].rr;
      @(negedge clk);
      check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
      if (i > 0) check($sformatf("v%0d busy", i), 32'(busy), 32'(prev_valid | (|vecs[i].rv)));
      @(posedge clk); #1;
      check($sformatf("v%0d res_valid", i), 32'(res_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d res_data", i), 32'(res_data), 32'(vecs[i].exp_data));
        check($sformatf("v%0d res_id", i), 32'(res_id), 32'(vecs[i].exp_id));
      end
      prev_valid = vecs[i].exp_valid;
    end

    // pointer is 1 here; all requesters pending with a consumer that stalls every
    // other cycle -> strict rotation 1,2,3,0,1,2 with every result observed once
    begin
      int exp_id;
      int got;
      int cyc;
      exp_id = 1; got = 0; cyc = 0;
      req_valid = 4'hF;
      while (got < 6 && cyc < 40) begin
        res_ready = cyc[0];
        @(negedge clk);
        if (res_valid && res_ready) begin
          check($sformatf("rot%0d res_id", got), 32'(res_id), 32'((exp_id + 3) % 4));
          check($sformatf("rot%0d res_data", got), 32'(res_data), 32'(res_of[(exp_id + 3) % 4]));
        end
        if (|req_ready) begin
          check($sformatf("rot%0d req_ready", got), 32'(req_ready), 32'(4'b0001 << exp_id));
          exp_id = (exp_id + 1) % 4;
          got++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check("rot grant count", 32'(got), 32'd6);
      req_valid = 4'h0; res_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("drain res_valid", 32'(res_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
